// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: button-driven RAM write/readback controller.
// Owns a DEPTH x DATA_W synchronous single-port RAM and one address pointer.
// MANUAL mode writes at the pointer and steps it from buttons. SCAN mode also steps the
// pointer on its own every TICK_DIV cycles.
// Ports:
//   clk       - single rising-edge clock
//   rst       - asynchronous active-high reset
//   btn[2:0]  - raw async buttons: [0] write, [1] manual step, [2] mode toggle
//   wr_data   - word written on a write event
//   q         - registered read data for address
//   address   - current pointer
//   q_valid   - q reflects mem[address] at its current contents
//   wren      - high on the cycle whose closing edge commits a write
//   scan_mode - 0 = MANUAL, 1 = SCAN
module ram_scan_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DEPTH       = 16384,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic              q_valid,
  output logic              wren,
  output logic              scan_mode
);

  localparam int unsigned       CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(TICK_DIV - 1);

  typedef enum logic {StManual, StScan} mode_e;

  mode_e                           mode_q, mode_d;
  logic [SYNC_STAGES-1:0][2:0]     sync_q;
  logic [2:0]                      prev_q;
  logic [2:0]                      evt_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               q_q;
  logic                            q_valid_q;
  logic [DATA_W-1:0]               mem [DEPTH];

  logic wr_evt, step_evt, tog_evt, tick, advance;

  assign wr_evt   = evt_q[0];
  assign step_evt = evt_q[1];
  assign tog_evt  = evt_q[2];

  // Synchroniser chain plus registered rising-edge detector; evt_q is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
      evt_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // All events are judged under the current mode; a toggle only takes effect afterwards.
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    tick    = (mode_q == StScan) && (cnt_q == LAST_TICK);
    advance = wr_evt || (step_evt && (mode_q == StManual)) || tick;

    if (tog_evt) begin
      mode_d = (mode_q == StManual) ? StScan : StManual;
      cnt_d  = '0;
    end else if (mode_q == StScan) begin
      cnt_d = (wr_evt || tick) ? '0 : cnt_q + CNT_W'(1);
    end

    // At most one increment per cycle, however many events coincide.
    if (advance) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= StManual;
      cnt_q     <= '0;
      addr_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      q_q       <= mem[addr_q];
      // q sampled at the new address only one edge after the pointer moves.
      q_valid_q <= ~advance;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_evt) begin
      mem[addr_q] <= wr_data;
    end
  end

  assign q         = q_q;
  assign address   = addr_q;
  assign q_valid   = q_valid_q;
  assign wren      = wr_evt;
  assign scan_mode = (mode_q == StScan);

endmodule
